// File: rtl/debounce_pkg.sv
// Shared constants for the debounce bank: board clock rate and default window lengths.
package debounce_pkg;

  localparam int unsigned CLK_HZ                  = 16_000_000;
  localparam int unsigned DEBOUNCE_STABLE_DEFAULT = 512;
  localparam int unsigned DEBOUNCE_HOLD_DEFAULT   = 8_000_000;

  // Converts a duration in milliseconds into clk cycles at the board clock rate.
  function automatic int unsigned cycles_from_ms(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: two-flop synchroniser, restartable stability counter, level and strobes.
// Long-press strobe is built only when DEBOUNCE_BANK_HOLD_EN is defined; otherwise hold is tied low.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT,
  parameter int unsigned INIT_LEVEL    = 1,
  parameter int unsigned ACTIVE_LEVEL  = 0,
  parameter int unsigned HOLD_CYCLES   = DEBOUNCE_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic        INIT_BIT = (INIT_LEVEL != 0);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_chan: STABLE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("debounce_chan: HOLD_CYCLES must be at least 1");
  end
  if (INIT_LEVEL > 1 || ACTIVE_LEVEL > 1) begin : g_bad_level
    $error("debounce_chan: INIT_LEVEL and ACTIVE_LEVEL must be 0 or 1");
  end

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchroniser stages s1/s2, then the stability window on s2; the counter
  // restarts on any bounce back to the current level, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= INIT_BIT;
      s2    <= INIT_BIT;
      level <= INIT_BIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef DEBOUNCE_BANK_HOLD_EN
  localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_CYCLES);
  localparam logic ACTIVE_BIT = (ACTIVE_LEVEL != 0);

  logic [HCNT_W-1:0] hcnt;

  function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
    return (v == HCNT_MAX) ? v : v + HCNT_W'(1);
  endfunction

  // Hold stage: the registered level is still inactive on the entering edge,
  // so the count starts from zero there and hold lands HOLD_CYCLES later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (level != ACTIVE_BIT) begin
        hcnt <= '0;
      end else begin
        hcnt <= sat_inc(hcnt);
        hold <= (hcnt != HCNT_MAX) && (sat_inc(hcnt) == HCNT_MAX);
      end
    end
  end
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced channels for pulled-up buttons and encoder contacts.
// Define DEBOUNCE_BANK_HOLD_EN to build the per-channel long-press (hold) strobe.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT,
  parameter int unsigned INIT_LEVEL    = 1,
  parameter int unsigned ACTIVE_LEVEL  = 0,
  parameter int unsigned HOLD_CYCLES   = DEBOUNCE_HOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .INIT_LEVEL   (INIT_LEVEL),
      .ACTIVE_LEVEL (ACTIVE_LEVEL),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .in   (in[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expected strobes are queued with their edge index
// when inputs are driven, and matched against every strobe the DUT produces.
module tb_debounce_bank;

  localparam int unsigned SC  = 4;
  localparam int unsigned HC  = 16;
  localparam int unsigned LAT = SC + 2;
`ifdef DEBOUNCE_BANK_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  hold;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] hold;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  ev_t         q[$];

  debounce_bank #(
    .CHANNELS     (4),
    .STABLE_CYCLES(SC),
    .INIT_LEVEL   (1),
    .ACTIVE_LEVEL (0),
    .HOLD_CYCLES  (HC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .level(level),
    .rise (rise),
    .fall (fall),
    .hold (hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int unsigned at, input logic [3:0] r, input logic [3:0] f,
                           input logic [3:0] h);
    ev_t e;
    e.cyc  = at;
    e.rise = r;
    e.fall = f;
    e.hold = h;
    q.push_back(e);
  endtask

  // Advance n active edges, then step just past the edge before driving inputs.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, cyc is the index of the edge just taken.
  always @(negedge clk) begin
    ev_t e;
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_strobe", cyc, e.cyc);
    end
    if (cyc != 0 && (rise | fall | hold) !== 4'b0000) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", {20'd0, rise, fall, hold}, 32'd0);
      end else begin
        e = q.pop_front();
        check("strobe_edge", cyc, e.cyc);
        check("rise", rise, e.rise);
        check("fall", fall, e.fall);
        check("hold", hold, e.hold);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned f;
    int unsigned r;
    rst = 1'b1;
    in  = 4'b1111;
    tick(1);
    check("rst_level", level, 4'b1111);
    check("rst_strobes", {20'd0, rise, fall, hold}, 32'd0);
    tick(4);
    rst = 1'b0;
    tick(20);
    check("idle_level", level, 4'b1111);

    // Single channel falls, level changes exactly LAT edges after the drive.
    in = 4'b1110;
    expect_ev(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(LAT - 1);
    check("pre_update_level", level, 4'b1111);
    tick(1);
    check("fall0_level", level, 4'b1110);
    tick(4);
    in = 4'b1111;
    expect_ev(cyc + LAT, 4'b0001, 4'b0000, 4'b0000);
    tick(LAT + 4);
    check("rise0_level", level, 4'b1111);

    // Bouncing every 2 cycles never settles; the final low edge does.
    for (int i = 0; i < 10; i++) begin
      in[1] = ~in[1];
      tick(2);
    end
    in[1] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
    tick(LAT + 4);
    check("bounce1_level", level, 4'b1101);
    in[1] = 1'b1;
    expect_ev(cyc + LAT, 4'b0010, 4'b0000, 4'b0000);
    tick(LAT + 4);

    // Glitches shorter than the window are swallowed.
    for (int n = 1; n <= 3; n++) begin
      in[2] = 1'b0;
      tick(n);
      in[2] = 1'b1;
      tick(8);
    end
    check("glitch2_level", level, 4'b1111);

    // A pulse of exactly SC cycles is just long enough.
    in[2] = 1'b0;
    expect_ev(cyc + LAT, 4'b0000, 4'b0100, 4'b0000);
    tick(SC);
    in[2] = 1'b1;
    expect_ev(cyc + LAT, 4'b0100, 4'b0000, 4'b0000);
    tick(LAT + 4);
    check("pulse2_level", level, 4'b1111);

    // All channels together.
    in = 4'b0000;
    expect_ev(cyc + LAT, 4'b0000, 4'b1111, 4'b0000);
    tick(LAT + 4);
    check("all_low_level", level, 4'b0000);
    in = 4'b1111;
    expect_ev(cyc + LAT, 4'b1111, 4'b0000, 4'b0000);
    tick(LAT + 4);
    check("all_high_level", level, 4'b1111);

    // Long press on channel 3: one hold strobe, no repeat.
    in = 4'b0111;
    f = cyc + LAT;
    expect_ev(f, 4'b0000, 4'b1000, 4'b0000);
    if (HOLD_ON) expect_ev(f + HC, 4'b0000, 4'b0000, 4'b1000);
    tick(LAT + HC + 30);
    check("press3_level", level, 4'b0111);
    in = 4'b1111;
    expect_ev(cyc + LAT, 4'b1000, 4'b0000, 4'b0000);
    tick(LAT + 4);

    // Reset part-way through a press discards the hold count.
    in = 4'b0111;
    f = cyc + LAT;
    expect_ev(f, 4'b0000, 4'b1000, 4'b0000);
    tick(LAT + 8);
    rst = 1'b1;
    tick(1);
    check("rst_mid_level", level, 4'b1111);
    tick(3);
    rst = 1'b0;
    r = cyc;
    check("rst_release_level", level, 4'b1111);
    expect_ev(r + LAT, 4'b0000, 4'b1000, 4'b0000);
    if (HOLD_ON) expect_ev(r + LAT + HC, 4'b0000, 4'b0000, 4'b1000);
    tick(LAT + HC + 10);
    check("repress3_level", level, 4'b0111);
    in = 4'b1111;
    expect_ev(cyc + LAT, 4'b1000, 4'b0000, 4'b0000);
    tick(LAT + 4);

    check("final_level", level, 4'b1111);
    check("final_hold", hold, 4'b0000);
    check("pending_events", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
